// File: rtl/clock_health_monitor_if.sv
// -----------------------------------------------------------------------------
// clock_health_monitor_if
//
// Groups the frequency-sample bus and the LMK reload handshake between the
// clock health monitor and its neighbours (frequency counter + uWire loader).
//
// Signals
//   sample_stb   1-cycle pulse: fc_osc/fc_td carry a new window result
//   fc_osc[31:0] oscillator frequency count for the last window (Hz)
//   fc_td[31:0]  TD clock frequency count for the last window (Hz)
//   reload_done  1-cycle pulse from the loader: uWire reload finished
//   reload_req   level from the monitor: reload requested, held until done
//
// Modports
//   master  frequency counter / loader side (drives samples and reload_done)
//   slave   monitor side (consumes samples, drives reload_req)
// -----------------------------------------------------------------------------
interface clock_health_monitor_if;
  logic        sample_stb;
  logic [31:0] fc_osc;
  logic [31:0] fc_td;
  logic        reload_done;
  logic        reload_req;

  modport master (
    output sample_stb,
    output fc_osc,
    output fc_td,
    output reload_done,
    input  reload_req
  );

  modport slave (
    input  sample_stb,
    input  fc_osc,
    input  fc_td,
    input  reload_done,
    output reload_req
  );
endinterface

// File: rtl/clock_health_monitor.sv
// -----------------------------------------------------------------------------
// clock_health_monitor
//
// Supervises the clock subsystem from the 125 MHz oscillator domain. Each
// measurement window delivers an oscillator and a TD frequency count; these
// are checked against their nominal values with an inclusive tolerance. The
// LMK and MMCM lock flags arrive asynchronously and are synchronised here.
// Clocks are declared good after a run of good samples; a run of bad samples
// or any loss of lock raises a fault, which requests a reload of the LMK
// configuration. Reloads are bounded; once exhausted the monitor parks in
// DEAD until software clears the sticky flags.
//
// Ports
//   clk            in   125 MHz oscillator clock
//   rst_n          in   synchronous reset, active low
//   mon_if         slave modport: sample bus + reload handshake
//   cc_locked      in   LMK lock flag, asynchronous
//   mmcm_locked    in   MMCM lock flag, asynchronous
//   clr_sticky     in   1-cycle pulse: clear sticky flags and leave DEAD
//   clk_ok         out  1 only while in OK (registered, lags OK entry by 1)
//   fault_osc      out  sticky: oscillator sample out of tolerance seen
//   fault_td       out  sticky: TD sample out of tolerance seen
//   fault_lol      out  sticky: loss of lock seen
//   lol_count      out  loss-of-lock events, saturating at 16'hFFFF
//   reload_count   out  reloads issued since reset / clr_sticky
//   state          out  FSM state code (INIT=0 OK=1 FAULT=2 RELOAD=3
//                       HOLDOFF=4 DEAD=5)
// -----------------------------------------------------------------------------
module clock_health_monitor #(
  parameter int unsigned FREQ_OSC_NOM   = 125000000,
  parameter int unsigned FREQ_TD_NOM    = 250000000,
  parameter int unsigned TOL_HZ         = 50000,
  parameter int unsigned GOOD_COUNT     = 4,
  parameter int unsigned BAD_COUNT      = 2,
  parameter int unsigned HOLDOFF_CYCLES = 125000000,
  parameter int unsigned MAX_RELOADS    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  clock_health_monitor_if.slave        mon_if,
  input  logic                         cc_locked,
  input  logic                         mmcm_locked,
  input  logic                         clr_sticky,
  output logic                         clk_ok,
  output logic                         fault_osc,
  output logic                         fault_td,
  output logic                         fault_lol,
  output logic [15:0]                  lol_count,
  output logic [3:0]                   reload_count,
  output logic [2:0]                   state
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_OK      = 3'd1,
    ST_FAULT   = 3'd2,
    ST_RELOAD  = 3'd3,
    ST_HOLDOFF = 3'd4,
    ST_DEAD    = 3'd5
  } state_e;

  // Nominal values and tolerance widened to 33-bit signed so that a count
  // below nominal yields a negative difference instead of wrapping.
  localparam logic signed [32:0] OSC_NOM_S = 33'(FREQ_OSC_NOM);
  localparam logic signed [32:0] TD_NOM_S  = 33'(FREQ_TD_NOM);
  localparam logic signed [32:0] TOL_S     = 33'(TOL_HZ);

  localparam logic [3:0]  GOOD_N    = 4'(GOOD_COUNT);
  localparam logic [3:0]  BAD_N     = 4'(BAD_COUNT);
  localparam logic [3:0]  MAX_N     = 4'(MAX_RELOADS);
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);

  // |count - nominal| <= TOL_HZ, inclusive on both sides.
  function automatic logic in_tol(input logic [31:0] cnt,
                                  input logic signed [32:0] nom);
    logic signed [32:0] diff;
    diff = $signed({1'b0, cnt}) - nom;
    return (diff <= TOL_S) && (diff >= -TOL_S);
  endfunction

  // ---------------------------------------------------------------------------
  // Lock synchronisers and loss-of-lock edge detect
  // ---------------------------------------------------------------------------
  logic cc_meta, cc_sync;
  logic mmcm_meta, mmcm_sync;
  logic lock_ok, lock_ok_q;
  logic lol_event;

  // NOTE: reset is sampled inside the clocked block (synchronous); the
  // synchroniser flops are cleared too so lock_ok starts low and its first
  // rise after reset is never mistaken for a loss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_meta   <= 1'b0;
      cc_sync   <= 1'b0;
      mmcm_meta <= 1'b0;
      mmcm_sync <= 1'b0;
      lock_ok_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, which is what gives the two-stage synchroniser its depth.
      cc_meta   <= cc_locked;
      cc_sync   <= cc_meta;
      mmcm_meta <= mmcm_locked;
      mmcm_sync <= mmcm_meta;
      lock_ok_q <= lock_ok;
    end
  end

  assign lock_ok   = cc_sync & mmcm_sync;
  // One-cycle pulse on the 1->0 transition of the synchronised lock.
  assign lol_event = lock_ok_q & ~lock_ok;

  // ---------------------------------------------------------------------------
  // Sample check pipeline: results registered one cycle after sample_stb
  // ---------------------------------------------------------------------------
  state_e state_q;
  logic   sample_vld;
  logic   osc_good;
  logic   td_good;
  logic   sample_good;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_vld <= 1'b0;
      osc_good   <= 1'b0;
      td_good    <= 1'b0;
    end else begin
      // Strobes arriving while the LMK settles are dropped at the source.
      sample_vld <= mon_if.sample_stb && (state_q != ST_HOLDOFF);
      osc_good   <= in_tol(mon_if.fc_osc, OSC_NOM_S);
      td_good    <= in_tol(mon_if.fc_td,  TD_NOM_S);
    end
  end

  // Lock state is judged at the time the FSM consumes the sample.
  assign sample_good = osc_good & td_good & lock_ok;

  // ---------------------------------------------------------------------------
  // Supervisor FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic [3:0]  good_cnt;
  logic [3:0]  bad_cnt;
  logic [31:0] hold_cnt;
  logic [3:0]  reload_count_q;
  logic        reload_req_q;
  logic        clk_ok_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_INIT;
      good_cnt       <= '0;
      bad_cnt        <= '0;
      hold_cnt       <= '0;
      reload_count_q <= '0;
      reload_req_q   <= 1'b0;
      clk_ok_q       <= 1'b0;
    end else begin
      clk_ok_q <= (state_q == ST_OK);

      // Clearing the sticky flags also restarts the reload budget.
      if (clr_sticky) begin
        reload_count_q <= '0;
      end

      case (state_q)
        ST_INIT: begin
          // A lock loss counts as a bad sample: qualification restarts.
          if (lol_event || (sample_vld && !sample_good)) begin
            good_cnt <= '0;
          end else if (sample_vld) begin
            if (good_cnt + 4'd1 == GOOD_N) begin
              state_q  <= ST_OK;
              good_cnt <= '0;
              bad_cnt  <= '0;
            end else begin
              good_cnt <= good_cnt + 4'd1;
            end
          end
        end

        ST_OK: begin
          if (lol_event) begin
            state_q  <= ST_FAULT;
            good_cnt <= '0;
            bad_cnt  <= '0;
          end else if (sample_vld) begin
            if (!sample_good) begin
              if (bad_cnt + 4'd1 == BAD_N) begin
                state_q  <= ST_FAULT;
                good_cnt <= '0;
                bad_cnt  <= '0;
              end else begin
                bad_cnt <= bad_cnt + 4'd1;
              end
            end else begin
              bad_cnt <= '0;
            end
          end
        end

        // Single-cycle decision point: retry while budget remains.
        ST_FAULT: begin
          good_cnt <= '0;
          bad_cnt  <= '0;
          if (reload_count_q < MAX_N) begin
            state_q        <= ST_RELOAD;
            reload_count_q <= reload_count_q + 4'd1;
            reload_req_q   <= 1'b1;
          end else begin
            state_q <= ST_DEAD;
          end
        end

        ST_RELOAD: begin
          if (mon_if.reload_done) begin
            state_q      <= ST_HOLDOFF;
            reload_req_q <= 1'b0;
            hold_cnt     <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
          end
        end

        // Entered with hold_cnt=0, so INIT follows exactly HOLDOFF_CYCLES
        // cycles after entry.
        ST_HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) begin
            state_q  <= ST_INIT;
            good_cnt <= '0;
            bad_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end

        ST_DEAD: begin
          if (clr_sticky) begin
            state_q  <= ST_INIT;
            good_cnt <= '0;
            bad_cnt  <= '0;
          end
        end

        default: begin
          state_q  <= ST_INIT;
          good_cnt <= '0;
          bad_cnt  <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky fault flags and loss-of-lock counter
  // ---------------------------------------------------------------------------
  logic        osc_set;
  logic        td_set;
  logic [15:0] lol_count_q;

  assign osc_set = sample_vld & ~osc_good & (state_q != ST_HOLDOFF);
  assign td_set  = sample_vld & ~td_good  & (state_q != ST_HOLDOFF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_osc   <= 1'b0;
      fault_td    <= 1'b0;
      fault_lol   <= 1'b0;
      lol_count_q <= '0;
    end else begin
      // A set event in the same cycle as clr_sticky keeps the flag high.
      fault_osc <= osc_set   | (fault_osc & ~clr_sticky);
      fault_td  <= td_set    | (fault_td  & ~clr_sticky);
      fault_lol <= lol_event | (fault_lol & ~clr_sticky);
      if (lol_event && (lol_count_q != 16'hFFFF)) begin
        lol_count_q <= lol_count_q + 16'd1;
      end
    end
  end

  assign mon_if.reload_req = reload_req_q;
  assign clk_ok            = clk_ok_q;
  assign lol_count         = lol_count_q;
  assign reload_count      = reload_count_q;
  assign state             = state_q;

endmodule

// File: tb/tb_clock_health_monitor.sv
// -----------------------------------------------------------------------------
// tb_clock_health_monitor
//
// Directed bench for clock_health_monitor with a short holdoff. Each sample
// strobe pushes the FSM state it should produce onto a scoreboard queue; the
// entry is popped and compared once the monitor has consumed the sample.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_clock_health_monitor;

  localparam int unsigned OSC_NOM = 125000000;
  localparam int unsigned TD_NOM  = 250000000;
  localparam int unsigned TOL     = 50000;
  localparam int unsigned HOLD    = 100;

  localparam logic [31:0] OSC_OK  = 32'(OSC_NOM);
  localparam logic [31:0] TD_OK   = 32'(TD_NOM);
  localparam logic [31:0] OSC_HI  = 32'(OSC_NOM + TOL);      // inclusive edge
  localparam logic [31:0] TD_LO   = 32'(TD_NOM - TOL);       // inclusive edge
  localparam logic [31:0] OSC_BAD = 32'(OSC_NOM - TOL - 1);
  localparam logic [31:0] TD_BAD  = 32'd250050001;

  localparam logic [2:0] S_INIT = 3'd0, S_OK = 3'd1, S_FAULT = 3'd2,
                         S_RELOAD = 3'd3, S_HOLDOFF = 3'd4, S_DEAD = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cc_locked, mmcm_locked, clr_sticky;
  logic        clk_ok, fault_osc, fault_td, fault_lol;
  logic [15:0] lol_count;
  logic [3:0]  reload_count;
  logic [2:0]  state;

  clock_health_monitor_if mon_if ();

  clock_health_monitor #(
    .FREQ_OSC_NOM   (OSC_NOM),
    .FREQ_TD_NOM    (TD_NOM),
    .TOL_HZ         (TOL),
    .GOOD_COUNT     (4),
    .BAD_COUNT      (2),
    .HOLDOFF_CYCLES (HOLD),
    .MAX_RELOADS    (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mon_if       (mon_if),
    .cc_locked    (cc_locked),
    .mmcm_locked  (mmcm_locked),
    .clr_sticky   (clr_sticky),
    .clk_ok       (clk_ok),
    .fault_osc    (fault_osc),
    .fault_td     (fault_td),
    .fault_lol    (fault_lol),
    .lol_count    (lol_count),
    .reload_count (reload_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] st;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: observed=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      check(e.tag, 32'(state), 32'(e.st));
    end
  endtask

  // One-cycle strobe; the FSM acts on it two falling edges later.
  task automatic strobe(input string tag, input logic [31:0] osc,
                        input logic [31:0] td, input logic [2:0] exp_st);
    exp_t e;
    mon_if.sample_stb = 1'b1;
    mon_if.fc_osc     = osc;
    mon_if.fc_td      = td;
    tick(1);
    mon_if.sample_stb = 1'b0;
    e.tag = tag;
    e.st  = exp_st;
    sb_q.push_back(e);
    tick(1);
    pop_check();
  endtask

  // Four good samples from INIT, then clk_ok one cycle later.
  task automatic qualify(input string tag);
    strobe({tag, "_g1"}, OSC_OK, TD_OK, S_INIT);
    strobe({tag, "_g2"}, OSC_OK, TD_OK, S_INIT);
    strobe({tag, "_g3"}, OSC_OK, TD_OK, S_INIT);
    strobe({tag, "_g4"}, OSC_OK, TD_OK, S_OK);
    tick(1);
    check({tag, "_clk_ok"}, 32'(clk_ok), 32'd1);
  endtask

  // Finish a reload from RELOAD and track the holdoff to INIT.
  task automatic do_reload(input string tag, input bit with_strobe);
    mon_if.reload_done = 1'b1;
    tick(1);
    mon_if.reload_done = 1'b0;
    check({tag, "_holdoff_entry"}, 32'(state), 32'(S_HOLDOFF));
    check({tag, "_req_drop"}, 32'(mon_if.reload_req), 32'd0);
    if (with_strobe) begin
      strobe({tag, "_holdoff_stb"}, OSC_BAD, TD_BAD, S_HOLDOFF);
      check({tag, "_holdoff_no_osc"}, 32'(fault_osc), 32'd0);
      tick(HOLD - 3);
    end else begin
      tick(HOLD - 1);
    end
    check({tag, "_holdoff_last"}, 32'(state), 32'(S_HOLDOFF));
    tick(1);
    check({tag, "_holdoff_exit"}, 32'(state), 32'(S_INIT));
  endtask

  initial begin
    logic [16:0] lol_exp;

    rst_n              = 1'b0;
    cc_locked          = 1'b1;
    mmcm_locked        = 1'b1;
    clr_sticky         = 1'b0;
    mon_if.sample_stb  = 1'b0;
    mon_if.fc_osc      = '0;
    mon_if.fc_td       = '0;
    mon_if.reload_done = 1'b0;
    tick(3);

    // Reset state
    check("rst_state", 32'(state), 32'(S_INIT));
    check("rst_clk_ok", 32'(clk_ok), 32'd0);
    check("rst_reload_req", 32'(mon_if.reload_req), 32'd0);
    check("rst_flags", {29'd0, fault_osc, fault_td, fault_lol}, 32'd0);
    check("rst_lol_count", 32'(lol_count), 32'd0);
    check("rst_reload_count", 32'(reload_count), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // 1: qualification, including both inclusive tolerance edges
    strobe("t1_s1", OSC_OK, TD_OK, S_INIT);
    strobe("t1_s2", OSC_HI, TD_OK, S_INIT);
    strobe("t1_s3", OSC_OK, TD_LO, S_INIT);
    strobe("t1_s4", OSC_OK, TD_OK, S_OK);
    check("t1_clk_ok_lag", 32'(clk_ok), 32'd0);
    tick(1);
    check("t1_clk_ok", 32'(clk_ok), 32'd1);
    check("t1_no_req", 32'(mon_if.reload_req), 32'd0);
    check("t1_no_flags", {29'd0, fault_osc, fault_td, fault_lol}, 32'd0);

    // reload_done outside RELOAD is ignored
    mon_if.reload_done = 1'b1;
    tick(1);
    mon_if.reload_done = 1'b0;
    check("stray_done_state", 32'(state), 32'(S_OK));
    check("stray_done_req", 32'(mon_if.reload_req), 32'd0);

    // 2: isolated bad sample keeps OK; two consecutive fault
    strobe("t2_bad1", OSC_OK, TD_BAD, S_OK);
    strobe("t2_good", OSC_OK, TD_OK, S_OK);
    strobe("t2_bad2", OSC_OK, TD_BAD, S_OK);
    check("t2_fault_td", 32'(fault_td), 32'd1);
    strobe("t2_bad3", OSC_OK, TD_BAD, S_FAULT);
    tick(1);
    check("t2_reload_state", 32'(state), 32'(S_RELOAD));
    check("t2_reload_req", 32'(mon_if.reload_req), 32'd1);
    check("t2_reload_count", 32'(reload_count), 32'd1);
    check("t2_clk_ok_low", 32'(clk_ok), 32'd0);
    check("t2_fault_osc", 32'(fault_osc), 32'd0);

    // 4: reload handshake and holdoff, strobe inside holdoff ignored
    do_reload("t4", 1'b1);
    check("t4_fault_td_kept", 32'(fault_td), 32'd1);

    // 3: loss of lock in OK
    qualify("t3q");
    cc_locked = 1'b0;
    tick(2);
    check("t3_pre_fault", 32'(state), 32'(S_OK));
    tick(1);
    check("t3_fault", 32'(state), 32'(S_FAULT));
    check("t3_fault_lol", 32'(fault_lol), 32'd1);
    check("t3_lol_count", 32'(lol_count), 32'd1);
    tick(1);
    check("t3_reload", 32'(state), 32'(S_RELOAD));
    check("t3_reload_count", 32'(reload_count), 32'd2);
    tick(6);
    cc_locked = 1'b1;
    tick(3);
    do_reload("t3", 1'b0);

    // 5: exhaust reloads
    qualify("t5q1");
    strobe("t5_bad1", OSC_BAD, TD_OK, S_OK);
    strobe("t5_bad2", OSC_BAD, TD_OK, S_FAULT);
    tick(1);
    check("t5_reload_count3", 32'(reload_count), 32'd3);
    do_reload("t5", 1'b0);
    qualify("t5q2");
    strobe("t5_bad3", OSC_BAD, TD_OK, S_OK);
    strobe("t5_bad4", OSC_OK, TD_BAD, S_FAULT);
    tick(1);
    check("t5_dead", 32'(state), 32'(S_DEAD));
    check("t5_dead_count", 32'(reload_count), 32'd3);
    check("t5_dead_req", 32'(mon_if.reload_req), 32'd0);
    tick(1);
    check("t5_dead_clk_ok", 32'(clk_ok), 32'd0);
    strobe("t5_dead_stb", OSC_OK, TD_BAD, S_DEAD);
    clr_sticky = 1'b1;
    tick(1);
    clr_sticky = 1'b0;
    check("t5_clr_state", 32'(state), 32'(S_INIT));
    check("t5_clr_flags", {29'd0, fault_osc, fault_td, fault_lol}, 32'd0);
    check("t5_clr_reload_count", 32'(reload_count), 32'd0);
    check("t5_clr_lol_count", 32'(lol_count), 32'd1);

    // 6: clr_sticky coincident with a bad-osc check
    mon_if.sample_stb = 1'b1;
    mon_if.fc_osc     = OSC_BAD;
    mon_if.fc_td      = TD_OK;
    tick(1);
    mon_if.sample_stb = 1'b0;
    clr_sticky        = 1'b1;
    sb_q.push_back('{tag: "t6_state", st: S_INIT});
    tick(1);
    clr_sticky = 1'b0;
    pop_check();
    check("t6_fault_osc_wins", 32'(fault_osc), 32'd1);
    check("t6_fault_td", 32'(fault_td), 32'd0);

    // 6: lol_count saturation, preloaded near the top
    force dut.lol_count_q = 16'hFFFC;
    tick(1);
    release dut.lol_count_q;
    check("t6_preload", 32'(lol_count), 32'h0000FFFC);
    for (int i = 0; i < 5; i++) begin
      cc_locked = 1'b0;
      tick(3);
      cc_locked = 1'b1;
      tick(3);
      lol_exp = 17'h0FFFC + 17'(i + 1);
      if (lol_exp > 17'h0FFFF) lol_exp = 17'h0FFFF;
      check($sformatf("t6_sat_%0d", i), 32'(lol_count), 32'(lol_exp));
    end
    check("t6_sat_state", 32'(state), 32'(S_INIT));

    // Lock loss in INIT restarts qualification, no fault
    strobe("li_g1", OSC_OK, TD_OK, S_INIT);
    strobe("li_g2", OSC_OK, TD_OK, S_INIT);
    strobe("li_g3", OSC_OK, TD_OK, S_INIT);
    mmcm_locked = 1'b0;
    tick(3);
    strobe("li_nolock", OSC_OK, TD_OK, S_INIT);
    check("li_lol_count_sat", 32'(lol_count), 32'h0000FFFF);
    mmcm_locked = 1'b1;
    tick(3);
    qualify("liq");

    // Reset in the middle of RELOAD drops reload_req at once
    strobe("rr_bad1", OSC_BAD, TD_OK, S_OK);
    strobe("rr_bad2", OSC_BAD, TD_OK, S_FAULT);
    tick(1);
    check("rr_reload_req", 32'(mon_if.reload_req), 32'd1);
    check("rr_reload_count", 32'(reload_count), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("rr_req_drop", 32'(mon_if.reload_req), 32'd0);
    check("rr_state", 32'(state), 32'(S_INIT));
    check("rr_lol_count", 32'(lol_count), 32'd0);
    check("rr_reload_count0", 32'(reload_count), 32'd0);
    rst_n = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
